// File: rtl/reg_file_bank_if.sv
// Bundle of the write-back, register-read and debug-dump signals of the
// register bank. The master side is the pipeline/debug unit, the slave side
// is the register bank itself.
interface reg_file_bank_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  i_reg_write;
    logic [ADDR_WIDTH-1:0] i_write_register;
    logic [DATA_WIDTH-1:0] i_write_data;
    logic [ADDR_WIDTH-1:0] i_read_register_1;
    logic [ADDR_WIDTH-1:0] i_read_register_2;
    logic [DATA_WIDTH-1:0] o_read_data_1;
    logic [DATA_WIDTH-1:0] o_read_data_2;
    logic                  i_dump_start;
    logic                  i_dump_ready;
    logic                  o_dump_valid;
    logic [ADDR_WIDTH-1:0] o_dump_index;
    logic [DATA_WIDTH-1:0] o_dump_data;
    logic                  o_dump_busy;
    logic                  o_dump_done;

    modport master (
        output i_reg_write, i_write_register, i_write_data,
        output i_read_register_1, i_read_register_2,
        output i_dump_start, i_dump_ready,
        input  o_read_data_1, o_read_data_2,
        input  o_dump_valid, o_dump_index, o_dump_data,
        input  o_dump_busy, o_dump_done
    );

    modport slave (
        input  i_reg_write, i_write_register, i_write_data,
        input  i_read_register_1, i_read_register_2,
        input  i_dump_start, i_dump_ready,
        output o_read_data_1, o_read_data_2,
        output o_dump_valid, o_dump_index, o_dump_data,
        output o_dump_busy, o_dump_done
    );
endinterface

// File: rtl/reg_file_bank.sv
// MIPS general-purpose register bank: one write port from WB, two
// combinational read ports to ID with write-through bypass, and a handshaked
// debug dump that streams every register in index order.
module reg_file_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic           clk,
    input  logic           reset,
    reg_file_bank_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR   = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA  = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } dump_state_t;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    dump_state_t           r_state;
    dump_state_t           w_state_next;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [ADDR_WIDTH-1:0] w_index_next;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;
    logic [DATA_WIDTH-1:0] w_dump_data;

    // Read rule shared by both ID ports and the dump port: register 0 is
    // hard-wired to zero, and a write landing this cycle wins over storage.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  we,
        input logic [ADDR_WIDTH-1:0] waddr,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [DATA_WIDTH-1:0] stored
    );
        logic [DATA_WIDTH-1:0] value;
        if (addr == ZERO_ADDR) begin
            value = ZERO_DATA;
        end else if (we && (addr == waddr)) begin
            value = wdata;
        end else begin
            value = stored;
        end
        return value;
    endfunction

    assign w_wr_en = bus.i_reg_write && (bus.i_write_register != ZERO_ADDR);

    // Register storage: clear on reset, otherwise accept WB writes (never reg 0).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= ZERO_DATA;
            end
        end else if (w_wr_en) begin
            r_regs[bus.i_write_register] <= bus.i_write_data;
        end
    end

    // Dump FSM state and stream index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_index <= ZERO_ADDR;
        end else begin
            r_state <= w_state_next;
            r_index <= w_index_next;
        end
    end

    // Dump FSM next state: start is only honoured in IDLE, the index only
    // moves on an accepted word, and DONE always lasts exactly one cycle.
    always_comb begin
        w_state_next = r_state;
        w_index_next = r_index;
        case (r_state)
            ST_IDLE: begin
                w_index_next = ZERO_ADDR;
                if (bus.i_dump_start) begin
                    w_state_next = ST_STREAM;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (bus.i_dump_ready) begin
                    if (r_index == LAST_INDEX) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_index_next = r_index + ONE_ADDR;
                    end
                end else begin
                    w_state_next = ST_STREAM;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                w_index_next = ZERO_ADDR;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_index_next = ZERO_ADDR;
            end
        endcase
    end

    // Read and dump data paths, all using the same bypass rule.
    always_comb begin
        w_rd1       = read_port(bus.i_read_register_1, bus.i_reg_write,
                                bus.i_write_register, bus.i_write_data,
                                r_regs[bus.i_read_register_1]);
        w_rd2       = read_port(bus.i_read_register_2, bus.i_reg_write,
                                bus.i_write_register, bus.i_write_data,
                                r_regs[bus.i_read_register_2]);
        w_dump_data = read_port(r_index, bus.i_reg_write,
                                bus.i_write_register, bus.i_write_data,
                                r_regs[r_index]);
    end

    assign bus.o_read_data_1 = w_rd1;
    assign bus.o_read_data_2 = w_rd2;
    assign bus.o_dump_data   = w_dump_data;
    assign bus.o_dump_index  = r_index;
    assign bus.o_dump_valid  = (r_state == ST_STREAM);
    assign bus.o_dump_busy   = (r_state != ST_IDLE);
    assign bus.o_dump_done   = (r_state == ST_DONE);
endmodule
